// File: rtl/game_over_ctrl_pkg.sv
// Shared constants for the game-state controller and its score counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  // FSM state encoding, kept as plain 2-bit constants so older blocks can
  // compare against the same values.
  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  // One BCD digit, and the saturation value of a 4-digit BCD counter.
  localparam int          BCD_W    = 4;
  localparam logic [15:0] BCD_MAX  = 16'h9999;

  // Default tuning: overlap pixels per frame for a hit, frames of game-over
  // hold before restart, frames per score increment.
  localparam int DEF_HIT_PIXELS  = 4;
  localparam int DEF_HOLD_FRAMES = 60;
  localparam int DEF_SCORE_DIV   = 6;

endpackage

// File: rtl/game_over_ctrl_if.sv
// Bundle of per-pixel/per-frame inputs and game-state outputs of game_over_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
//   master: drives frame_tick, video_on, is_player, is_obstacle, btn_jump
//   slave : drives hit, run_en, start_pulse, score[15:0] (4 BCD digits)
interface game_over_ctrl_if;
  logic        frame_tick;
  logic        video_on;
  logic        is_player;
  logic        is_obstacle;
  logic        btn_jump;
  logic        hit;
  logic        run_en;
  logic        start_pulse;
  logic [15:0] score;

  modport master (
    output frame_tick, video_on, is_player, is_obstacle, btn_jump,
    input  hit, run_en, start_pulse, score
  );

  modport slave (
    input  frame_tick, video_on, is_player, is_obstacle, btn_jump,
    output hit, run_en, start_pulse, score
  );
endinterface

// File: rtl/game_over_ctrl_bcd_counter4.sv
// 4-digit BCD counter with clear and increment, saturating at 9999.
// Latency: 1 cycle from clr_i/inc_i to q_o.
// Backpressure: none; inc_i at 9999 is dropped.
//   clk, reset (sync, active-high), clr_i (priority over inc_i), inc_i, q_o[15:0]
module bcd_counter4
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] q_o
);

  logic [15:0]      q_q, q_d;
  logic             carry;
  logic [BCD_W-1:0] dig;

  // Ripple a +1 from the units digit upward; a 9 wraps to 0 and passes the
  // carry on, anything else absorbs it.
  always_comb begin
    q_d   = q_q;
    carry = 1'b0;
    dig   = '0;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != BCD_MAX)) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        dig = q_q[i*BCD_W +: BCD_W];
        if (carry) begin
          if (dig == 4'd9) begin
            q_d[i*BCD_W +: BCD_W] = '0;
          end else begin
            q_d[i*BCD_W +: BCD_W] = dig + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/game_over_ctrl.sv
// Game-state FSM: per-frame collision decision, game-over hold, restart, BCD score.
// Latency: hit/run_en/start_pulse/score change 1 cycle after the deciding input.
// Backpressure: none; held button gives a single edge, RUN ignores the button.
//   clk, reset (sync, active-high)
//   bus (slave): frame_tick, video_on, is_player, is_obstacle, btn_jump in;
//                hit, run_en, start_pulse, score[15:0] out
module game_over_ctrl
  import game_pkg::*;
#(
  parameter int HIT_PIXELS  = DEF_HIT_PIXELS,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int SCORE_DIV   = DEF_SCORE_DIV
)
(
  input  logic             clk,
  input  logic             reset,
  game_over_ctrl_if.slave  bus
);

  logic [1:0] state_q, state_d;
  logic       btn_prev_q;
  logic [7:0] ovl_cnt_q, ovl_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       start_q, start_d;
  logic       score_clr, score_inc;

  logic btn_rise, overlap, restart_ok;

  assign btn_rise   = bus.btn_jump & ~btn_prev_q;
  // The tick cycle itself is blanking; it never counts as an overlap pixel.
  assign overlap    = bus.video_on & bus.is_player & bus.is_obstacle & ~bus.frame_tick;
  // Registered hold count, so an edge on the tick that completes the hold is
  // still too early.
  assign restart_ok = (hold_cnt_q == 8'(HOLD_FRAMES));

  always_comb begin
    state_d    = state_q;
    ovl_cnt_d  = ovl_cnt_q;
    hold_cnt_d = hold_cnt_q;
    div_cnt_d  = div_cnt_q;
    start_d    = 1'b0;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    case (state_q)
      ST_READY: begin
        ovl_cnt_d = '0;
        if (btn_rise) begin
          state_d   = ST_RUN;
          start_d   = 1'b1;
          score_clr = 1'b1;
          div_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (bus.frame_tick) begin
          ovl_cnt_d = '0;
          // Collision wins over the score tick that may land on this frame.
          if (ovl_cnt_q >= 8'(HIT_PIXELS)) begin
            state_d    = ST_OVER;
            hold_cnt_d = '0;
          end else if (div_cnt_q == 8'(SCORE_DIV - 1)) begin
            div_cnt_d = '0;
            score_inc = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end else if (overlap && (ovl_cnt_q != 8'hFF)) begin
          ovl_cnt_d = ovl_cnt_q + 8'd1;
        end
      end
      ST_OVER: begin
        ovl_cnt_d = '0;
        if (btn_rise && restart_ok) begin
          state_d   = ST_RUN;
          start_d   = 1'b1;
          score_clr = 1'b1;
          div_cnt_d = '0;
        end else if (bus.frame_tick && !restart_ok) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_READY;
        ovl_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_READY;
      btn_prev_q <= 1'b0;
      ovl_cnt_q  <= '0;
      hold_cnt_q <= '0;
      div_cnt_q  <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= bus.btn_jump;
      ovl_cnt_q  <= ovl_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      div_cnt_q  <= div_cnt_d;
      start_q    <= start_d;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .reset (reset),
    .clr_i (score_clr),
    .inc_i (score_inc),
    .q_o   (bus.score)
  );

  assign bus.hit         = (state_q == ST_OVER);
  assign bus.run_en      = (state_q == ST_RUN);
  assign bus.start_pulse = start_q;

endmodule

// File: doc/game_over_ctrl.md
Name: game_over_ctrl

Overview:
- Game-state controller that produces the `hit` level consumed by the GAME OVER text overlay.
- Detects player/obstacle pixel overlap while the VGA scan is active and decides collision once per frame.
- Holds the game-over state for a minimum number of frames, then restarts on a jump-button press.
- Runs a 4-digit BCD survival score; sits between the VGA sync generator, the sprite drawers and the overlay/score drawers.

Parameters:
- HIT_PIXELS, 4: overlapping pixels in one frame required to declare a collision (1..255).
- HOLD_FRAMES, 60: frames the game-over state is held before restart is accepted (1..255).
- SCORE_DIV, 6: frames per score increment (1..255).

Ports:
- clk  in  1  system pixel clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blanking
- video_on  in  1  current (x,y) is in the visible area
- is_player  in  1  player sprite pixel at current (x,y)
- is_obstacle  in  1  obstacle pixel at current (x,y)
- btn_jump  in  1  jump button, already synchronized/debounced level
- hit  out  1  game over; drives the overlay enable
- run_en  out  1  game running; gates sprite motion
- start_pulse  out  1  one-cycle pulse when RUN is entered
- score  out  16  4 BCD digits, [15:12] thousands … [3:0] units

Behaviour:
- Clock and reset:
  - Single clock `clk`. Reset is synchronous and active-high on `reset`.
  - Reset (including mid-operation) forces READY, hit=0, run_en=0, start_pulse=0, score=0, all counters 0, btn_prev=0.
- Button edge: btn_rise = btn_jump & ~btn_prev, where btn_prev is registered every cycle. A held button never generates a second edge.
- States:
  - READY: hit=0, run_en=0. btn_rise → RUN. Score clears to 0 on entry to RUN.
  - RUN: hit=0, run_en=1.
  - OVER: hit=1, run_en=0. Score frozen.
- Overlap counting (RUN only):
  - ovl_cnt (8-bit, saturating at 255) increments on cycles with video_on & is_player & is_obstacle & ~frame_tick.
  - On frame_tick: if ovl_cnt >= HIT_PIXELS → OVER; otherwise stay in RUN. ovl_cnt clears to 0 in either case.
  - ovl_cnt is held at 0 outside RUN.
- Hold counter:
  - On entry to OVER, hold_cnt clears to 0.
  - Each frame_tick in OVER increments hold_cnt, saturating at HOLD_FRAMES.
  - restart_ok = (hold_cnt == HOLD_FRAMES), evaluated on the registered value.
  - btn_rise in OVER with restart_ok → RUN.
  - btn_rise in the same cycle as the frame_tick that completes the hold is ignored; restart needs a later edge.
- Score (RUN only):
  - div_cnt counts frame_ticks. On reaching SCORE_DIV-1 it wraps to 0 and the score increments.
  - BCD increment: a digit equal to 9 rolls to 0 with carry into the next digit. Score saturates at 9999.
  - On the frame_tick that transitions to OVER, no score increment occurs.
  - div_cnt clears on entry to RUN.
- start_pulse: registered, high for exactly the first cycle in RUN, on both READY→RUN and OVER→RUN.
- Latency: hit rises the cycle after the deciding frame_tick. Outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.
- Simultaneous events: a frame_tick collision decision takes priority over a score increment in the same cycle. btn_rise in RUN has no effect.

Decomposition:
- Shared package (game_pkg): state encoding constants ST_READY=2'd0, ST_RUN=2'd1, ST_OVER=2'd2; BCD digit width; default HIT_PIXELS, HOLD_FRAMES and SCORE_DIV values.
- One sub-module, bcd_counter4: sync reset, clear, inc, 16-bit BCD out, saturating at 9999. Reused later by the high-score block.
- FSM, edge detect, overlap and hold counters stay in game_over_ctrl.

Test Plan:
- Reset then btn_jump 0→1 → start_pulse high for 1 cycle, run_en=1, score=0x0000, hit=0.
- RUN with 3 overlap pixels in a frame, then frame_tick (HIT_PIXELS=4) → stays RUN. Next frame with 4 pixels, then frame_tick → hit=1 one cycle later, run_en=0.
- RUN for 60 frame_ticks with SCORE_DIV=6 and no overlap → score=0x0010. Preload near 0x0099, run 6 more frames → 0x0100. Force 9999 → stays 0x9999.
- In OVER, button edge after 59 frame_ticks → ignored, hit=1. Edge after the 60th frame_tick (later cycle) → RUN, start_pulse, score=0.
- Button held high across the OVER hold expiry → no restart until released and re-pressed. Edge coincident with the completing frame_tick → ignored.
- reset asserted mid-RUN with score=0x0042 → next cycle READY, score=0, hit=0, run_en=0. Overlap pixels while in READY → ovl_cnt stays 0.
